data_mem_responder: RTL and testbench

//  Responder end of the core's data-memory interface: accepts the core's load/store requests
//  (mem_func strobe), serves them from on-chip word RAM or memory-mapped I/O registers, and

---
 rtl/mem_map_pkg.sv | 55 +++++
 rtl/word_ram.sv | 25 ++
 rtl/data_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared definitions for the data-memory responder: I/O map, region and FSM encodings,
// the latched request payload and the address decoder.
package mem_map_pkg;

    localparam logic [31:0] IO_BASE_DEF = 32'h1000_0000;
    localparam logic [31:0] LED_OFF     = 32'h0000_0000;
    localparam logic [31:0] SW_OFF      = 32'h0000_0004;
    localparam logic [31:0] CNT_OFF     = 32'h0000_0008;

    // Wait counter width; supports RAM_LATENCY 0..15.
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_CNT,
        REG_ERR
    } region_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    // Store payload captured when a request is accepted.
    typedef struct packed {
        logic        we;
        logic [31:0] wdata;
    } req_t;

    // Classify a byte address; misaligned or unmapped addresses land in REG_ERR.
    function automatic region_t decode_region(
        input logic [31:0] addr,
        input logic [31:0] io_base,
        input logic [31:0] ram_bytes
    );
        region_t r;
        r = REG_ERR;
        if (addr[1:0] != 2'b00) begin
            r = REG_ERR;
        end else if (addr < ram_bytes) begin
            r = REG_RAM;
        end else if (addr == io_base + LED_OFF) begin
            r = REG_LED;
        end else if (addr == io_base + SW_OFF) begin
            r = REG_SW;
        end else if (addr == io_base + CNT_OFF) begin
            r = REG_CNT;
        end
        return r;
    endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous word RAM, read-before-write, no reset (block-RAM inferable).
// Ports: clk; we write enable; addr word address; wdata write data; rdata registered read data.
module word_ram #(
    parameter  int unsigned DEPTH = 1024,
    parameter  int unsigned W     = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage array and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory port: serves loads/stores from word RAM or
// memory-mapped I/O (LED register, synchronised switches, free-running cycle counter)
// with a multicycle latency and a one-cycle mem_done pulse.
// Ports: clk, reset (async active-low); mem_func request strobe; data_mem_addr byte address;
//        data_mem_wr_data / data_mem_wr_en store data and direction; data_mem_rd_data load data;
//        mem_done completion pulse; mem_err request error; sw_in board switches; led_out LEDs.
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RAM_LATENCY = 2,
    parameter logic [31:0] IO_BASE     = IO_BASE_DEF,
    parameter int unsigned LED_W       = 16,
    parameter int unsigned SW_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_func,
    input  logic [31:0]      data_mem_addr,
    input  logic [31:0]      data_mem_wr_data,
    input  logic             data_mem_wr_en,
    output logic [31:0]      data_mem_rd_data,
    output logic             mem_done,
    output logic             mem_err,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    state_t              state, state_n;
    region_t             region, region_n;
    req_t                req, req_n;
    logic [WAIT_W-1:0]   wait_cnt, wait_n;
    logic [AW-1:0]       word_idx, word_idx_n;
    logic [31:0]         rd_n;
    logic                done_n;
    logic                err_n;
    logic [LED_W-1:0]    led_n;

    logic [31:0]         cycle_cnt;
    logic [SW_W-1:0]     sw_meta, sw_sync;

    logic                ram_we_c;
    logic [AW-1:0]       ram_addr_c;
    logic [31:0]         ram_rdata;

    // In IDLE the RAM is addressed straight from the request so the read is
    // already in flight on the accept edge; afterwards it uses the latched index.
    assign ram_addr_c = (state == IDLE) ? data_mem_addr[AW+1:2] : word_idx;

    word_ram #(
        .DEPTH (DEPTH_WORDS),
        .W     (32)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (req.wdata),
        .rdata (ram_rdata)
    );

    // Next-state, side effects and response values.
    always_comb begin
        state_n    = state;
        region_n   = region;
        req_n      = req;
        wait_n     = wait_cnt;
        word_idx_n = word_idx;
        rd_n       = data_mem_rd_data;
        done_n     = 1'b0;
        err_n      = mem_err;
        led_n      = led_out;
        ram_we_c   = 1'b0;

        case (state)
            IDLE: begin
                if (mem_func) begin
                    state_n    = WAIT;
                    region_n   = decode_region(data_mem_addr, IO_BASE, RAM_BYTES);
                    req_n.we    = data_mem_wr_en;
                    req_n.wdata = data_mem_wr_data;
                    word_idx_n = data_mem_addr[AW+1:2];
                    wait_n     = (region_n == REG_RAM) ? WAIT_W'(RAM_LATENCY) : '0;
                    err_n      = 1'b0;
                end
            end
            WAIT: begin
                if (wait_cnt != '0) begin
                    wait_n = wait_cnt - WAIT_W'(1);
                end else begin
                    // Leaving WAIT: commit the store or capture the load value.
                    state_n = DONE;
                    done_n  = 1'b1;
                    err_n   = (region == REG_ERR);
                    case (region)
                        REG_RAM: begin
                            if (req.we) ram_we_c = 1'b1;
                            else        rd_n     = ram_rdata;
                        end
                        REG_LED: begin
                            if (req.we) led_n = req.wdata[LED_W-1:0];
                            else        rd_n  = 32'(led_out);
                        end
                        REG_SW: begin
                            if (!req.we) rd_n = 32'(sw_sync);
                        end
                        REG_CNT: begin
                            if (!req.we) rd_n = cycle_cnt;
                        end
                        default: begin
                            rd_n = '0;
                        end
                    endcase
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            region           <= REG_RAM;
            req              <= '0;
            wait_cnt         <= '0;
            word_idx         <= '0;
            data_mem_rd_data <= '0;
            mem_done         <= 1'b0;
            mem_err          <= 1'b0;
            led_out          <= '0;
        end else begin
            state            <= state_n;
            region           <= region_n;
            req              <= req_n;
            wait_cnt         <= wait_n;
            word_idx         <= word_idx_n;
            data_mem_rd_data <= rd_n;
            mem_done         <= done_n;
            mem_err          <= err_n;
            led_out          <= led_n;
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous switches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a transaction-level model predicts the
// completion cycle, response data, error flag and LED state of each request; a per-cycle
// compare process checks the DUT against it, and directed literals pin the model.
module tb_data_mem_responder;

    localparam int unsigned L   = 2;
    localparam logic [31:0] IOB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_func = 1'b0;
    logic [31:0] data_mem_addr = '0;
    logic [31:0] data_mem_wr_data = '0;
    logic        data_mem_wr_en = 1'b0;
    logic [31:0] data_mem_rd_data;
    logic        mem_done;
    logic        mem_err;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk              (clk),
        .reset            (reset),
        .mem_func         (mem_func),
        .data_mem_addr    (data_mem_addr),
        .data_mem_wr_data (data_mem_wr_data),
        .data_mem_wr_en   (data_mem_wr_en),
        .data_mem_rd_data (data_mem_rd_data),
        .mem_done         (mem_done),
        .mem_err          (mem_err),
        .sw_in            (sw_in),
        .led_out          (led_out)
    );

    int total = 0;
    int bad   = 0;

    // Edge count and the value the DUT cycle counter must hold in the current cycle.
    int unsigned cyc = 0;
    logic [31:0] cnt_m;
    int          force_evt = 0;
    int          force_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_m <= '0;
        end else if (force_evt != force_seen) begin
            cnt_m      <= 32'hFFFF_FFFF;
            force_seen <= force_evt;
        end else begin
            cnt_m <= cnt_m + 32'd1;
        end
    end

    // Model state.
    logic [31:0] ram_m [int unsigned];
    logic [15:0] led_m = '0;
    logic [31:0] cur_rd = '0;

    // Expectation for the request in flight.
    bit          exp_valid = 1'b0;
    int unsigned exp_cyc = 0;
    bit          exp_we, exp_err, exp_cnt, exp_led_wr;
    logic [31:0] exp_rd;
    logic [15:0] exp_led_val;

    logic [31:0] last_rd;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model.
    task automatic compare_loop();
        bit hit;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cur_rd = '0;
                led_m  = '0;
                chk("rst_done", 32'(mem_done), 32'd0);
                chk("rst_err",  32'(mem_err),  32'd0);
                chk("rst_rd",   data_mem_rd_data, 32'd0);
                chk("rst_led",  32'(led_out),  32'd0);
            end else begin
                hit = exp_valid && (cyc == exp_cyc);
                if (hit) begin
                    if (exp_led_wr) led_m = exp_led_val;
                    if (exp_err)      cur_rd = '0;
                    else if (!exp_we) cur_rd = exp_cnt ? (cnt_m - 32'd1) : exp_rd;
                    chk("err", 32'(mem_err), 32'(exp_err));
                end
                chk("done", 32'(mem_done), 32'(hit));
                chk("rd_data", data_mem_rd_data, cur_rd);
                chk("led", 32'(led_out), 32'(led_m));
            end
        end
    endtask

    // Issue one request, build its expectation, wait for completion and check latency.
    task automatic req(input logic [31:0] a, input logic [31:0] wd, input bit we,
                       input int unsigned lat_lit, input bit no_sync);
        int unsigned acc;
        int unsigned n;
        bit          is_ram;
        exp_err    = 1'b0;
        exp_cnt    = 1'b0;
        exp_led_wr = 1'b0;
        exp_rd     = '0;
        exp_we     = we;
        is_ram     = 1'b0;
        if (a[1:0] != 2'b00) begin
            exp_err = 1'b1;
        end else if (a < 32'd4096) begin
            is_ram = 1'b1;
            if (we) ram_m[a >> 2] = wd;
            else    exp_rd = ram_m[a >> 2];
        end else if (a == IOB) begin
            if (we) begin
                exp_led_wr  = 1'b1;
                exp_led_val = wd[15:0];
            end else begin
                exp_rd = {16'h0, led_m};
            end
        end else if (a == IOB + 32'd4) begin
            exp_rd = {16'h0, sw_in};
        end else if (a == IOB + 32'd8) begin
            exp_cnt = 1'b1;
        end else begin
            exp_err = 1'b1;
        end

        if (!no_sync) begin
            @(posedge clk);
            #1;
        end
        data_mem_addr    = a;
        data_mem_wr_data = wd;
        data_mem_wr_en   = we;
        mem_func         = 1'b1;
        acc       = cyc + 1;
        exp_cyc   = acc + 1 + (is_ram ? L : 0);
        exp_valid = 1'b1;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_done && n < 40);
        if (!mem_done) begin
            total++;
            bad++;
            $display("FAIL timeout: no mem_done for addr %h within %0d cycles", a, n);
        end else begin
            chk("latency", 32'(cyc - acc + 1), 32'(lat_lit));
        end
        last_rd  = data_mem_rd_data;
        last_err = mem_err;

        @(posedge clk);
        #1;
        mem_func  = 1'b0;
        exp_valid = 1'b0;
    endtask

    initial begin
        fork
            compare_loop();
        join_none

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Reset in the middle of a RAM store: no completion, no write, LEDs cleared.
        req(32'h0000_0014, 32'h1111_1111, 1'b1, 4, 1'b0);
        req(IOB, 32'h0000_00FF, 1'b1, 2, 1'b0);
        chk("t1_led_pre", 32'(led_out), 32'h0000_00FF);
        @(posedge clk);
        #1;
        data_mem_addr    = 32'h0000_0014;
        data_mem_wr_data = 32'h5555_5555;
        data_mem_wr_en   = 1'b1;
        mem_func         = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        mem_func = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("t1_led_rst", 32'(led_out), 32'd0);
        repeat (2) @(posedge clk);
        req(32'h0000_0014, 32'h0, 1'b0, 4, 1'b0);
        chk("t1_ram5", last_rd, 32'h1111_1111);

        // RAM store then load, plus the top RAM word and the first address above RAM.
        req(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 4, 1'b0);
        req(32'h0000_0010, 32'h0, 1'b0, 4, 1'b0);
        chk("t2_rd",  last_rd, 32'hDEAD_BEEF);
        chk("t2_err", 32'(last_err), 32'd0);
        req(32'h0000_0FFC, 32'hCAFE_F00D, 1'b1, 4, 1'b0);
        req(32'h0000_0FFC, 32'h0, 1'b0, 4, 1'b0);
        chk("ram_top", last_rd, 32'hCAFE_F00D);
        req(32'h0000_1000, 32'h0, 1'b0, 2, 1'b0);
        chk("ram_above_err", 32'(last_err), 32'd1);

        // LED register write/read.
        req(IOB, 32'h0001_A5A5, 1'b1, 2, 1'b0);
        chk("t3_led", 32'(led_out), 32'h0000_A5A5);
        req(IOB, 32'h0, 1'b0, 2, 1'b0);
        chk("t3_rd", last_rd, 32'h0000_A5A5);

        // Switch read, ignored store to the read-only switch register.
        sw_in = 16'h00F0;
        repeat (3) @(posedge clk);
        req(IOB + 32'd4, 32'h0, 1'b0, 2, 1'b0);
        chk("t4_sw", last_rd, 32'h0000_00F0);
        req(IOB + 32'd4, 32'hFFFF_FFFF, 1'b1, 2, 1'b0);
        chk("t4_ro_err", 32'(last_err), 32'd0);
        req(IOB + 32'd4, 32'h0, 1'b0, 2, 1'b0);
        chk("t4_sw_again", last_rd, 32'h0000_00F0);

        // Misaligned and unmapped accesses leave RAM and LEDs intact.
        req(32'h0000_0013, 32'h0, 1'b0, 2, 1'b0);
        chk("t5_mis_err", 32'(last_err), 32'd1);
        chk("t5_mis_rd",  last_rd, 32'd0);
        req(IOB + 32'hC, 32'h0, 1'b0, 2, 1'b0);
        chk("t5_unm_err", 32'(last_err), 32'd1);
        req(32'h0000_0011, 32'h1234_5678, 1'b1, 2, 1'b0);
        req(IOB + 32'hC, 32'h0000_0000, 1'b1, 2, 1'b0);
        req(32'h0000_0010, 32'h0, 1'b0, 4, 1'b0);
        chk("t5_ram_intact", last_rd, 32'hDEAD_BEEF);
        chk("t5_led_intact", 32'(led_out), 32'h0000_A5A5);

        // Counter wrap: preset just before the boundary, then two loads.
        @(posedge clk);
        #1;
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        force_evt++;
        #1 release dut.cycle_cnt;
        req(IOB + 32'd8, 32'h0, 1'b0, 2, 1'b1);
        chk("t6_cnt0", last_rd, 32'hFFFF_FFFF);
        req(IOB + 32'd8, 32'h0, 1'b0, 2, 1'b0);
        chk("t6_cnt1", last_rd, 32'h0000_0003);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
